// File: rtl/uart_rx_fifo_param_if.sv
// Host-side read bus of uart_rx_fifo_param: FIFO head, occupancy, pop and overrun control.
interface uart_rx_fifo_param_if #(
    parameter int DATA_WIDTH      = 8,
    parameter int FIFO_ADDR_WIDTH = 4
);
    logic                       read_en;
    logic                       ovr_clr_i;
    logic [DATA_WIDTH-1:0]      dout_o;
    logic                       parity_err_o;
    logic                       frame_err_o;
    logic                       fifo_full;
    logic                       fifo_empty;
    logic [FIFO_ADDR_WIDTH:0]   fifo_count_o;
    logic                       overrun_o;

    modport master (
        output read_en,
        output ovr_clr_i,
        input  dout_o,
        input  parity_err_o,
        input  frame_err_o,
        input  fifo_full,
        input  fifo_empty,
        input  fifo_count_o,
        input  overrun_o
    );

    modport slave (
        input  read_en,
        input  ovr_clr_i,
        output dout_o,
        output parity_err_o,
        output frame_err_o,
        output fifo_full,
        output fifo_empty,
        output fifo_count_o,
        output overrun_o
    );
endinterface

// File: rtl/uart_rx_fifo_param.sv
// Oversampling UART receiver with runtime character format and a first-word-fall-through receive FIFO.
// Defining UART_RX_BREAK_DETECT_EN adds break detection and the break_o output.
module uart_rx_fifo_param #(
    parameter int DATA_WIDTH      = 8,
    parameter int FIFO_DEPTH      = 16,
    parameter int FIFO_ADDR_WIDTH = 4,
    parameter int OVERSAMPLE      = 16,
    parameter int DIV_WIDTH       = 16
) (
    input  logic                 clk,
    input  logic                 rst,
`ifdef UART_RX_BREAK_DETECT_EN
    output logic                 break_o,
`endif
    input  logic                 rx_i,
    input  logic [DIV_WIDTH-1:0] baud_div_i,
    input  logic [3:0]           data_bits_i,
    input  logic                 parity_en_i,
    input  logic                 parity_odd_i,
    uart_rx_fifo_param_if.slave  bus
);

    localparam int SCNT_W  = $clog2(OVERSAMPLE);
    localparam int CNT_W   = FIFO_ADDR_WIDTH + 1;
    localparam int ENTRY_W = DATA_WIDTH + 2;

    localparam logic [SCNT_W-1:0] HALF_LAST = SCNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [SCNT_W-1:0] BIT_LAST  = SCNT_W'(OVERSAMPLE - 1);
    localparam logic [3:0]        MAX_BITS  = 4'(DATA_WIDTH);
    localparam logic [CNT_W-1:0]  DEPTH_CNT = CNT_W'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } rxState_t;

    rxState_t r_state;
    rxState_t w_stateNext;

    logic                  r_rxMeta;
    logic                  r_rxSync;
    logic                  r_armed;

    logic [DIV_WIDTH-1:0]  r_tickCnt;
    logic [DIV_WIDTH-1:0]  r_divReload;
    logic [DIV_WIDTH-1:0]  w_divReloadIn;
    logic                  w_tick;

    logic [SCNT_W-1:0]     r_sampleCnt;
    logic [SCNT_W-1:0]     w_cntLast;
    logic                  w_cntWrap;

    logic [3:0]            r_bitCnt;
    logic [3:0]            r_dataBits;
    logic [3:0]            w_dataBitsIn;
    logic                  r_parEn;
    logic                  r_parOdd;
    logic                  r_parityBit;
    logic [DATA_WIDTH-1:0] r_shift;
    logic [DATA_WIDTH-1:0] w_shiftNext;

    logic                  w_startDet;
    logic                  w_stopSample;
    logic                  w_push;
    logic                  w_parErr;

    logic [ENTRY_W-1:0]         r_mem [FIFO_DEPTH];
    logic [FIFO_ADDR_WIDTH-1:0] r_wrPtr;
    logic [FIFO_ADDR_WIDTH-1:0] r_rdPtr;
    logic [CNT_W-1:0]           r_count;
    logic                       r_overrun;
    logic                       w_full;
    logic                       w_empty;
    logic                       w_pop;
    logic                       w_wr;
    logic                       w_drop;
    logic [ENTRY_W-1:0]         w_head;

    // rx_i is asynchronous; both flops reset to the idle-high level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rxMeta <= 1'b1;
            r_rxSync <= 1'b1;
        end else begin
            r_rxMeta <= rx_i;
            r_rxSync <= r_rxMeta;
        end
    end

    assign w_divReloadIn = (baud_div_i == '0) ? '0 : baud_div_i - DIV_WIDTH'(1);
    assign w_dataBitsIn  = (data_bits_i < 4'd5 || data_bits_i > MAX_BITS) ? MAX_BITS : data_bits_i;

    assign w_tick    = (r_state != ST_IDLE) && (r_tickCnt == '0);
    assign w_cntLast = (r_state == ST_START) ? HALF_LAST : BIT_LAST;
    assign w_cntWrap = w_tick && (r_sampleCnt == w_cntLast);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    always_comb begin
        w_stateNext  = r_state;
        w_startDet   = 1'b0;
        w_stopSample = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (r_armed && !r_rxSync) begin
                    w_stateNext = ST_START;
                    w_startDet  = 1'b1;
                end
            end
            ST_START: begin
                if (w_cntWrap) begin
                    w_stateNext = r_rxSync ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (w_cntWrap && (r_bitCnt == r_dataBits - 4'd1)) begin
                    w_stateNext = r_parEn ? ST_PARITY : ST_STOP;
                end
            end
            ST_PARITY: begin
                if (w_cntWrap) begin
                    w_stateNext = ST_STOP;
                end
            end
            ST_STOP: begin
                if (w_cntWrap) begin
                    w_stateNext  = ST_IDLE;
                    w_stopSample = 1'b1;
                end
            end
            default: w_stateNext = ST_IDLE;
        endcase
    end

    always_comb begin
        w_shiftNext = r_shift;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            if (r_bitCnt == 4'(i)) begin
                w_shiftNext[i] = r_rxSync;
            end
        end
    end

    // Format and divisor are frozen at start-bit detection; a low stop bit leaves the receiver unarmed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_armed     <= 1'b0;
            r_tickCnt   <= '0;
            r_divReload <= '0;
            r_sampleCnt <= '0;
            r_bitCnt    <= '0;
            r_dataBits  <= MAX_BITS;
            r_parEn     <= 1'b0;
            r_parOdd    <= 1'b0;
            r_parityBit <= 1'b0;
            r_shift     <= '0;
        end else if (w_startDet) begin
            r_armed     <= 1'b0;
            r_tickCnt   <= w_divReloadIn;
            r_divReload <= w_divReloadIn;
            r_sampleCnt <= '0;
            r_bitCnt    <= '0;
            r_dataBits  <= w_dataBitsIn;
            r_parEn     <= parity_en_i;
            r_parOdd    <= parity_odd_i;
            r_parityBit <= 1'b0;
            r_shift     <= '0;
        end else begin
            if (w_stopSample) begin
                r_armed <= r_rxSync;
            end else if (r_state == ST_IDLE && r_rxSync) begin
                r_armed <= 1'b1;
            end

            if (r_state != ST_IDLE) begin
                r_tickCnt <= (r_tickCnt == '0) ? r_divReload : r_tickCnt - DIV_WIDTH'(1);
            end

            if (w_cntWrap) begin
                r_sampleCnt <= '0;
            end else if (w_tick) begin
                r_sampleCnt <= r_sampleCnt + SCNT_W'(1);
            end

            if (w_cntWrap && r_state == ST_DATA) begin
                r_shift  <= w_shiftNext;
                r_bitCnt <= r_bitCnt + 4'd1;
            end

            if (w_cntWrap && r_state == ST_PARITY) begin
                r_parityBit <= r_rxSync;
            end
        end
    end

    assign w_parErr = r_parEn & ((^r_shift) ^ r_parityBit ^ r_parOdd);

`ifdef UART_RX_BREAK_DETECT_EN
    logic w_isBreak;

    assign w_isBreak = w_stopSample && !r_rxSync && (r_shift == '0) && !r_parityBit;
    assign break_o   = w_isBreak;
    assign w_push    = w_stopSample && !w_isBreak;
`else
    assign w_push    = w_stopSample;
`endif

    assign w_full  = (r_count == DEPTH_CNT);
    assign w_empty = (r_count == '0);
    assign w_pop   = bus.read_en && !w_empty;
    assign w_wr    = w_push && (!w_full || w_pop);
    assign w_drop  = w_push && w_full && !w_pop;

    // Entry layout is {parity_err, frame_err, data}; storage needs no reset.
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wrPtr] <= {w_parErr, !r_rxSync, r_shift};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wrPtr   <= '0;
            r_rdPtr   <= '0;
            r_count   <= '0;
            r_overrun <= 1'b0;
        end else begin
            if (w_wr) begin
                r_wrPtr <= r_wrPtr + FIFO_ADDR_WIDTH'(1);
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + FIFO_ADDR_WIDTH'(1);
            end
            if (w_wr && !w_pop) begin
                r_count <= r_count + CNT_W'(1);
            end else if (w_pop && !w_wr) begin
                r_count <= r_count - CNT_W'(1);
            end
            if (w_drop) begin
                r_overrun <= 1'b1;
            end else if (bus.ovr_clr_i) begin
                r_overrun <= 1'b0;
            end
        end
    end

    assign w_head = r_mem[r_rdPtr];

    assign bus.dout_o       = w_empty ? '0 : w_head[DATA_WIDTH-1:0];
    assign bus.frame_err_o  = !w_empty && w_head[DATA_WIDTH];
    assign bus.parity_err_o = !w_empty && w_head[DATA_WIDTH+1];
    assign bus.fifo_full    = w_full;
    assign bus.fifo_empty   = w_empty;
    assign bus.fifo_count_o = r_count;
    assign bus.overrun_o    = r_overrun;

endmodule

// File: tb/tb_uart_rx_fifo_param.sv
// Randomised and directed bench for uart_rx_fifo_param against a queue-based character model.
module tb_uart_rx_fifo_param;

    localparam int DW    = 8;
    localparam int DEPTH = 16;
    localparam int AW    = 4;
    localparam int OS    = 16;
    localparam int DIVW  = 16;

    logic            clk = 1'b0;
    logic            rst;
    logic            rxLine;
    logic [DIVW-1:0] baudDiv;
    logic [3:0]      dataBits;
    logic            parEn;
    logic            parOdd;

    int checkCount = 0;
    int failCount  = 0;

    logic [DW+1:0] expQ [$];
    logic          expOvr;

    uart_rx_fifo_param_if #(.DATA_WIDTH(DW), .FIFO_ADDR_WIDTH(AW)) busIf ();

`ifdef UART_RX_BREAK_DETECT_EN
    logic breakPulse;
    int   breakCount = 0;

    always @(negedge clk) begin
        if (breakPulse) breakCount++;
    end
`endif

    uart_rx_fifo_param #(
        .DATA_WIDTH(DW),
        .FIFO_DEPTH(DEPTH),
        .FIFO_ADDR_WIDTH(AW),
        .OVERSAMPLE(OS),
        .DIV_WIDTH(DIVW)
    ) dut (
        .clk(clk),
        .rst(rst),
`ifdef UART_RX_BREAK_DETECT_EN
        .break_o(breakPulse),
`endif
        .rx_i(rxLine),
        .baud_div_i(baudDiv),
        .data_bits_i(dataBits),
        .parity_en_i(parEn),
        .parity_odd_i(parOdd),
        .bus(busIf.slave)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Expected FIFO entry {parity_err, frame_err, data} from the character as sent on the wire.
    function automatic logic [DW+1:0] modelEntry(input logic [8:0] data, input int nb, input bit pE,
                                                 input bit pO, input bit pB, input bit stopBit);
        logic [DW-1:0] d;
        bit            pe;
        d = '0;
        for (int i = 0; i < nb; i++) d[i] = data[i];
        pe = pE ? ((^d) ^ pB ^ pO) : 1'b0;
        return {pe, ~stopBit, d};
    endfunction

    task automatic modelPush(input logic [DW+1:0] ent);
        if (expQ.size() == DEPTH) expOvr = 1'b1;
        else expQ.push_back(ent);
    endtask

    task automatic checkState(input string tag);
        logic [DW+1:0] head;
        head = (expQ.size() > 0) ? expQ[0] : '0;
        checkOutput({tag, ".count"},   32'(busIf.fifo_count_o), 32'(expQ.size()));
        checkOutput({tag, ".empty"},   32'(busIf.fifo_empty),   32'(expQ.size() == 0));
        checkOutput({tag, ".full"},    32'(busIf.fifo_full),    32'(expQ.size() == DEPTH));
        checkOutput({tag, ".overrun"}, 32'(busIf.overrun_o),    32'(expOvr));
        checkOutput({tag, ".dout"},    32'(busIf.dout_o),       32'(head[DW-1:0]));
        checkOutput({tag, ".frameErr"},  32'(busIf.frame_err_o),  32'(head[DW]));
        checkOutput({tag, ".parityErr"}, 32'(busIf.parity_err_o), 32'(head[DW+1]));
    endtask

    task automatic driveLine(input logic level, input int cycles);
        rxLine = level;
        repeat (cycles) @(negedge clk);
    endtask

    task automatic readOne();
        busIf.read_en = 1'b1;
        @(negedge clk);
        busIf.read_en = 1'b0;
        if (expQ.size() > 0) void'(expQ.pop_front());
    endtask

    task automatic drain(input string tag, input int n);
        for (int k = 0; k < n; k++) begin
            checkState(tag);
            readOne();
        end
        checkState(tag);
    endtask

    task automatic clrOvr();
        busIf.ovr_clr_i = 1'b1;
        @(negedge clk);
        busIf.ovr_clr_i = 1'b0;
        expOvr = 1'b0;
    endtask

    // Sends one character; rstBit >= 0 pulses rst in the middle of that data bit.
    task automatic applyStimulus(input logic [8:0] data, input int reqBits, input bit pE, input bit pO,
                                 input bit pB, input bit stopBit, input int div, input int rstBit);
        int            bt;
        int            nb;
        logic [DW+1:0] ent;
        bit            brk;
        bit            aborted;
`ifdef UART_RX_BREAK_DETECT_EN
        int            brkBefore;
        brkBefore = breakCount;
`endif
        bt      = ((div == 0) ? 1 : div) * OS;
        nb      = (reqBits < 5 || reqBits > DW) ? DW : reqBits;
        ent     = modelEntry(data, nb, pE, pO, pB, stopBit);
        brk     = 1'b0;
        aborted = 1'b0;
`ifdef UART_RX_BREAK_DETECT_EN
        brk = (ent[DW-1:0] == '0) && !(pE && pB) && !stopBit;
`endif
        baudDiv  = DIVW'(div);
        dataBits = 4'(reqBits);
        parEn    = pE;
        parOdd   = pO;
        driveLine(1'b0, bt);
        baudDiv  = DIVW'($urandom_range(1, 300));
        dataBits = 4'($urandom_range(0, 15));
        parEn    = 1'($urandom_range(0, 1));
        parOdd   = 1'($urandom_range(0, 1));
        for (int i = 0; i < nb; i++) begin
            if (i == rstBit) begin
                rxLine = data[i];
                repeat (bt / 2) @(negedge clk);
                rst = 1'b1;
                expQ.delete();
                expOvr = 1'b0;
                repeat (2) @(negedge clk);
                rst = 1'b0;
                repeat (bt - bt / 2 - 2) @(negedge clk);
                aborted = 1'b1;
            end else begin
                driveLine(data[i], bt);
            end
        end
        if (pE) driveLine(pB, bt);
        rxLine = stopBit;
        repeat (bt / 4) @(negedge clk);
        checkOutput("preStopCount", 32'(busIf.fifo_count_o), 32'(expQ.size()));
        repeat (bt - bt / 4) @(negedge clk);
        driveLine(1'b1, 2 * bt);
        if (!aborted && !brk) modelPush(ent);
`ifdef UART_RX_BREAK_DETECT_EN
        checkOutput("breakPulses", 32'(breakCount - brkBefore), 32'(brk && !aborted));
`endif
    endtask

    initial begin
        logic [8:0] rd;
        int         rb;
        int         rdv;
        bit         rpe;
        bit         rpo;
        bit         rpb;
        bit         rsb;

        rst             = 1'b1;
        rxLine          = 1'b1;
        baudDiv         = DIVW'(2);
        dataBits        = 4'd8;
        parEn           = 1'b0;
        parOdd          = 1'b0;
        busIf.read_en   = 1'b0;
        busIf.ovr_clr_i = 1'b0;
        expOvr          = 1'b0;
        repeat (5) @(negedge clk);
        checkState("reset");
        rst = 1'b0;
        repeat (5) @(negedge clk);
        checkState("afterReset");

        $display("[TB] 8N1 0xA5 at divisor 78");
        applyStimulus(9'h0A5, 8, 1'b0, 1'b0, 1'b0, 1'b1, 78, -1);
        drain("a5", 1);

        $display("[TB] 7E1 parity error and clean parity");
        applyStimulus(9'h035, 7, 1'b1, 1'b0, 1'b1, 1'b1, 2, -1);
        applyStimulus(9'h035, 7, 1'b1, 1'b0, 1'b0, 1'b1, 2, -1);
        drain("parity", 2);

        $display("[TB] framing error then clean character");
        applyStimulus(9'h03C, 8, 1'b0, 1'b0, 1'b0, 1'b0, 2, -1);
        applyStimulus(9'h011, 8, 1'b0, 1'b0, 1'b0, 1'b1, 2, -1);
        applyStimulus(9'h000, 8, 1'b0, 1'b0, 1'b0, 1'b0, 2, -1);
        drain("frame", expQ.size());

        $display("[TB] fill to overrun");
        for (int i = 0; i < 17; i++) begin
            applyStimulus(9'(i), 8, 1'b0, 1'b0, 1'b0, 1'b1, 0, -1);
            if (i == 15) checkState("full");
        end
        checkState("overrun");
        drain("fillRead", 16);
        clrOvr();
        checkState("ovrClr");
        readOne();
        checkState("readEmpty");

        $display("[TB] start glitch on idle line");
        baudDiv = DIVW'(2);
        driveLine(1'b0, 10);
        driveLine(1'b1, 3 * 32);
        checkState("glitch");
        applyStimulus(9'h05A, 8, 1'b0, 1'b0, 1'b0, 1'b1, 2, -1);
        drain("glitch5A", 1);

        $display("[TB] reset during data bit 4");
        applyStimulus(9'h011, 8, 1'b0, 1'b0, 1'b0, 1'b1, 2, -1);
        applyStimulus(9'h0FF, 8, 1'b0, 1'b0, 1'b0, 1'b1, 2, 4);
        checkState("midReset");
        applyStimulus(9'h05A, 8, 1'b0, 1'b0, 1'b0, 1'b1, 2, -1);
        drain("reset5A", 1);

`ifdef UART_RX_BREAK_DETECT_EN
        begin
            int brkBase;
            $display("[TB] long break");
            brkBase  = breakCount;
            baudDiv  = DIVW'(2);
            dataBits = 4'd8;
            parEn    = 1'b0;
            driveLine(1'b0, 12 * 32);
            checkOutput("breakLong", 32'(breakCount - brkBase), 32'd1);
            checkState("breakLow");
            driveLine(1'b1, 2 * 32);
            checkState("breakHigh");
            applyStimulus(9'h042, 8, 1'b0, 1'b0, 1'b0, 1'b1, 2, -1);
            drain("break42", 1);
        end
`endif

        $display("[TB] randomised characters");
        for (int f = 0; f < 30; f++) begin
            rd  = 9'($urandom_range(0, 511));
            rb  = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 15) : $urandom_range(5, DW);
            rpe = 1'($urandom_range(0, 1));
            rpo = 1'($urandom_range(0, 1));
            rpb = 1'($urandom_range(0, 1));
            rsb = ($urandom_range(0, 6) != 0);
            rdv = $urandom_range(0, 3);
            if (f % 7 == 3) begin
                rd  = '0;
                rpb = 1'b0;
                rsb = 1'b0;
            end
            applyStimulus(rd, rb, rpe, rpo, rpb, rsb, rdv, -1);
            checkState("rand");
            if ($urandom_range(0, 2) == 0) drain("randRead", $urandom_range(0, expQ.size()));
            if ($urandom_range(0, 5) == 0) begin
                clrOvr();
                checkState("randClr");
            end
        end
        drain("final", expQ.size());

        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
        $finish;
    end

endmodule
